// File: rtl/ahb_slave_sram.sv
// ---------------------------------------------------------------------------
// ahb_slave_sram
//   AHB-Lite slave in front of a MEM_HEIGHT x 32-bit word-addressed SRAM.
//   - Pipelined address/data phases.
//   - Byte, halfword and word writes use per-lane byte enables.
//   - WAIT_STATES (0..15) data-phase wait cycles per NONSEQ/SEQ transfer.
//   - Reads sample the array at the edge that ends the address phase.
//     A write finishing on that same edge to the same word is forwarded.
//   Optional build macro AHB_SLV_ERR_EN:
//     Out-of-range address, HSIZE > word, or a misaligned access gives a
//     two-cycle ERROR response. The write is suppressed and HRDATA is kept.
//     When undefined, HRESP is 0 and the upper address bits wrap around.
//
// Ports
//   HCLK, HRESETn      clock, synchronous active-low reset
//   HSEL               slave select from the decoder
//   HADDR              byte address
//   HTRANS             transfer type
//   HWRITE             write strobe
//   HSIZE              transfer size
//   HBURST             burst type (ignored)
//   HWDATA             write data (data phase)
//   HREADY             bus-level ready from the mux
//   HRDATA             read data
//   HREADYOUT          slave ready
//   HRESP              0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
module ahb_slave_sram #(
  parameter int DWIDTH         = 32,
  parameter int AWIDTH         = 32,
  parameter int MEM_HEIGHT     = 1024,
  parameter int MEM_ADDR_WIDTH = $clog2(MEM_HEIGHT),
  parameter int WAIT_STATES    = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DWIDTH-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DWIDTH-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  logic [DWIDTH-1:0]         mem_q [MEM_HEIGHT];

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      pend_q;
  logic                      write_q;
  logic                      err_q;
  logic [MEM_ADDR_WIDTH-1:0] idx_q;
  logic [3:0]                lanes_q;
  logic [DWIDTH-1:0]         rdata_q;

  logic                      accept, addr_err, dp_done, do_write, do_read, fwd;
  logic [MEM_ADDR_WIDTH-1:0] idx_a;
  logic [DWIDTH-1:0]         wmask, merged;
  logic                      hready_out, hresp_out;

  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] size);
    case (size)
      3'b000:  lane_mask = 4'b0001 << a;
      3'b001:  lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  assign accept = HSEL & HTRANS[1] & HREADY;
  assign idx_a  = HADDR[MEM_ADDR_WIDTH+1:2];

`ifdef AHB_SLV_ERR_EN
  always_comb begin
    addr_err = (HADDR[AWIDTH-1:MEM_ADDR_WIDTH+2] != '0) ||
               (HSIZE > 3'b010) ||
               ((HSIZE == 3'b001) && HADDR[0]) ||
               ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  end
`else
  assign addr_err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{HBURST, HTRANS[0], HADDR[AWIDTH-1:MEM_ADDR_WIDTH+2]};

  // FSM: state register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. A new transfer may start whenever the current data
  // phase is completing (IDLE, ERR2, or WAIT with the counter expired).
  always_comb begin
    logic take;
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE, S_ERR2: take = 1'b1;
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               take  = 1'b1;
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      if (accept && addr_err) begin
        state_d = S_ERR1;
        cnt_d   = 4'd0;
      end else if (accept && (WAIT_STATES > 0)) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end else begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    hready_out = 1'b1;
    hresp_out  = 1'b0;
    case (state_q)
      S_WAIT: hready_out = (cnt_q == 4'd0);
      S_ERR1: begin
        hready_out = 1'b0;
        hresp_out  = 1'b1;
      end
      S_ERR2: hresp_out = 1'b1;
      default: ;
    endcase
  end

  assign dp_done  = pend_q & hready_out;
  assign do_write = dp_done & write_q & ~err_q;
  assign do_read  = accept & ~HWRITE & ~addr_err;

  always_comb begin
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{lanes_q[i]}};
  end

  // Word as it will look after the completing write; used for forwarding.
  assign merged = (mem_q[idx_q] & ~wmask) | (HWDATA & wmask);
  assign fwd    = do_write && (idx_q == idx_a);

  // Address phase -> data phase boundary
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (HREADY)  pend_q  <= accept;
      if (do_read) rdata_q <= fwd ? merged : mem_q[idx_a];
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) begin
      idx_q   <= idx_a;
      write_q <= HWRITE;
      lanes_q <= lane_mask(HADDR[1:0], HSIZE);
      err_q   <= addr_err;
    end
  end

  // Data phase end: commit write lanes (array itself is never reset)
  always_ff @(posedge HCLK) begin
    if (HRESETn && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_q[i]) mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA    = rdata_q;
  assign HREADYOUT = hready_out;
  assign HRESP     = hresp_out;

endmodule

// File: tb/tb_ahb_slave_sram.sv
module tb_ahb_slave_sram;

  localparam logic [1:0] IDLE_T = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        sel0, sel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata;
  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3, resp0, resp3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_sram #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy0),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_slave_sram #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy3),
    .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] s,
                         input logic [1:0] t);
    haddr  = a;
    hwrite = w;
    hsize  = s;
    htrans = t;
  endtask

  task automatic idle();
    htrans = IDLE_T;
    hwrite = 1'b0;
  endtask

  // Single NONSEQ transfer to one of the two slaves; returns wait count and read data.
  task automatic xfer(input bit ws3, input logic [31:0] a, input logic w, input logic [2:0] s,
                      input logic [31:0] wd, output int waits, output logic [31:0] rd);
    sel0 = !ws3;
    sel3 = ws3;
    addr_ph(a, w, s, NONSEQ);
    tick();
    idle();
    hwdata = wd;
    waits  = 0;
    while (((ws3 ? rdy3 : rdy0) == 1'b0) && (waits < 32)) begin
      waits++;
      tick();
    end
    if (waits >= 32) chk("xfer_timeout", waits, 0);
    rd = ws3 ? rdata3 : rdata0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          w, dpc, low, cur;
    logic [31:0] rd, exp0;
    logic [31:0] bvals [4];

    HRESETn = 1'b0;
    sel0 = 1'b0; sel3 = 1'b0;
    haddr = '0; htrans = IDLE_T; hwrite = 1'b0; hsize = 3'b010; hburst = 3'b000; hwdata = '0;
    repeat (2) tick();
    chk("rst_rdy0",  rdy0,   1);
    chk("rst_resp0", resp0,  0);
    chk("rst_rd0",   rdata0, 0);
    chk("rst_rdy3",  rdy3,   1);
    chk("rst_resp3", resp3,  0);
    chk("rst_rd3",   rdata3, 0);
    HRESETn = 1'b1;
    tick();

    // Write then back-to-back read of the same word, zero wait states
    sel0 = 1'b1; sel3 = 1'b0;
    addr_ph(32'h10, 1'b1, 3'b010, NONSEQ);
    tick();
    chk("t1_rdy_wdp", rdy0, 1);
    hwdata = 32'hDEADBEEF;
    addr_ph(32'h10, 1'b0, 3'b010, NONSEQ);
    tick();
    chk("t1_rdy_rdp", rdy0, 1);
    chk("t1_fwd", rdata0, 32'hDEADBEEF);
    idle();
    tick();

    // Byte write merged into a word, forwarded to the following read
    addr_ph(32'h20, 1'b1, 3'b010, NONSEQ);
    tick();
    hwdata = 32'h11223344;
    addr_ph(32'h21, 1'b1, 3'b000, NONSEQ);
    tick();
    hwdata = 32'h0000AA00;
    addr_ph(32'h20, 1'b0, 3'b010, NONSEQ);
    tick();
    chk("t2_byte_fwd", rdata0, 32'h1122AA44);
    idle();
    tick();
    xfer(1'b0, 32'h22, 1'b1, 3'b001, 32'h55660000, w, rd);
    chk("t2_hold_on_write", rdata0, 32'h1122AA44);
    xfer(1'b0, 32'h20, 1'b0, 3'b010, 32'h0, w, rd);
    chk("t2_half", rd, 32'h5566AA44);

    // Three wait states: single reads/writes and a 4-beat SEQ burst
    for (int i = 0; i < 4; i++) begin
      bvals[i] = 32'hB0000000 | (32'h01010101 * (i + 1));
      xfer(1'b1, 32'h40 + 4 * i, 1'b1, 3'b010, bvals[i], w, rd);
      if (i == 0) chk("t3_wr_waits", w, 3);
    end
    xfer(1'b1, 32'h40, 1'b0, 3'b010, 32'h0, w, rd);
    chk("t3_rd_waits", w, 3);
    chk("t3_rd_data", rd, 32'hB1010101);

    sel0 = 1'b0; sel3 = 1'b1;
    hburst = 3'b011;
    addr_ph(32'h40, 1'b0, 3'b010, NONSEQ);
    tick();
    dpc = 0; low = 0; cur = 0;
    while ((cur < 4) && (dpc < 64)) begin
      if (cur + 1 < 4) addr_ph(32'h40 + 4 * (cur + 1), 1'b0, 3'b010, SEQ);
      else             idle();
      dpc++;
      if (rdy3) begin
        chk($sformatf("burst_beat%0d", cur), rdata3, bvals[cur]);
        cur++;
      end else begin
        low++;
      end
      tick();
    end
    hburst = 3'b000;
    chk("burst_beats", cur, 4);
    chk("burst_dp_cycles", dpc, 16);
    chk("burst_low_cycles", low, 12);

    // Out-of-range write (wraps to word 0 when the error check is absent)
    xfer(1'b0, 32'h0, 1'b1, 3'b010, 32'h01020304, w, rd);
    sel0 = 1'b1; sel3 = 1'b0;
    addr_ph(32'h1000, 1'b1, 3'b010, NONSEQ);
    tick();
    idle();
    hwdata = 32'h99999999;
`ifdef AHB_SLV_ERR_EN
    chk("err1_resp", resp0, 1);
    chk("err1_rdy",  rdy0,  0);
    tick();
    chk("err2_resp", resp0, 1);
    chk("err2_rdy",  rdy0,  1);
    tick();
    chk("err_after_resp", resp0, 0);
    exp0 = 32'h01020304;
`else
    chk("oor_resp", resp0, 0);
    chk("oor_rdy",  rdy0,  1);
    tick();
    exp0 = 32'h99999999;
`endif
    xfer(1'b0, 32'h0, 1'b0, 3'b010, 32'h0, w, rd);
    chk("oor_readback", rd, exp0);

    // Reset in the middle of a write's wait cycles
    xfer(1'b1, 32'h80, 1'b1, 3'b010, 32'h12345678, w, rd);
    xfer(1'b1, 32'h80, 1'b0, 3'b010, 32'h0, w, rd);
    chk("rst_pre_read", rd, 32'h12345678);
    sel0 = 1'b0; sel3 = 1'b1;
    addr_ph(32'h80, 1'b1, 3'b010, NONSEQ);
    tick();
    idle();
    hwdata = 32'hFFFFFFFF;
    chk("rst_in_wait", rdy3, 0);
    tick();
    HRESETn = 1'b0;
    tick();
    chk("rst_mid_rdy",  rdy3,   1);
    chk("rst_mid_resp", resp3,  0);
    chk("rst_mid_rd",   rdata3, 0);
    HRESETn = 1'b1;
    repeat (4) tick();
    xfer(1'b1, 32'h80, 1'b0, 3'b010, 32'h0, w, rd);
    chk("rst_word_kept", rd, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
